// File: rtl/entry_pkg.sv
// Shared types, constants and helpers for the decimal operand entry path.
package entry_pkg;

    typedef enum logic [1:0] {
        S_TENS  = 2'd0,
        S_UNITS = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] STG_TENS  = 4'b0001;
    localparam logic [3:0] STG_UNITS = 4'b0010;
    localparam logic [3:0] STG_DONE  = 4'b0100;

    localparam logic [3:0] MAX_DIGIT = 4'd9;
    localparam int unsigned MAG_W    = 7;

    // Largest magnitude representable in a bits-wide two's-complement operand.
    function automatic logic [MAG_W-1:0] max_mag(input int unsigned bits, input logic neg);
        logic [MAG_W-1:0] lim;
        lim = MAG_W'(1) << (bits - 1);
        return neg ? lim : lim - MAG_W'(1);
    endfunction

    function automatic logic [3:0] stage_of(input state_e st);
        logic [3:0] stg;
        stg = STG_TENS;
        case (st)
            S_TENS:  stg = STG_TENS;
            S_UNITS: stg = STG_UNITS;
            S_DONE:  stg = STG_DONE;
            default: stg = STG_TENS;
        endcase
        return stg;
    endfunction

endpackage

// File: rtl/operand_entry_edge_pulse.sv
// Turns a debounced key level into a single-cycle press on each rising edge.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_press_c
);

    logic r_key_q;

    // Resetting to 1 keeps a key held through reset from registering as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_q <= 1'b1;
        end else begin
            r_key_q <= i_key;
        end
    end

    assign o_press_c = i_key & ~r_key_q;

endmodule

// File: rtl/operand_entry.sv
// Assembles operator-entered sign/tens/units BCD digits into a two's-complement operand.
module operand_entry
    import entry_pkg::*;
#(
    parameter int unsigned Bits = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key,
    input  logic [3:0]      digit,
    input  logic            neg,
    input  logic            ack,
    output logic [Bits-1:0] value,
    output logic            valid,
    output logic            err,
    output logic [3:0]      stage
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_tens;
    logic [3:0]        w_tens_nxt;
    logic [Bits-1:0]   r_value;
    logic [Bits-1:0]   w_value_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [3:0]        r_stage;

    logic              w_press;
    logic [MAG_W-1:0]  w_mag;
    logic [MAG_W-1:0]  w_neg_mag;
    logic              w_legal;

    edge_pulse u_edge (
        .clk       (clk),
        .rst       (rst),
        .i_key     (key),
        .o_press_c (w_press)
    );

    // tens <= 9 so the magnitude tops out at 99 and fits 7 bits.
    assign w_mag     = MAG_W'({3'b000, r_tens} * MAG_W'(10)) + MAG_W'({3'b000, digit});
    assign w_neg_mag = MAG_W'(0) - w_mag;
    assign w_legal   = (w_mag <= max_mag(Bits, neg));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_TENS;
            r_tens  <= 4'd0;
            r_value <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_stage <= STG_TENS;
        end else begin
            r_state <= w_state_nxt;
            r_tens  <= w_tens_nxt;
            r_value <= w_value_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_stage <= stage_of(w_state_nxt);
        end
    end

    // Digit entry; in DONE ack takes priority and presses are dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_tens_nxt  = r_tens;
        w_value_nxt = r_value;
        w_valid_nxt = r_valid;
        w_err_nxt   = 1'b0;
        case (r_state)
            S_TENS: begin
                if (w_press) begin
                    if (digit > MAX_DIGIT) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_tens_nxt  = digit;
                        w_state_nxt = S_UNITS;
                    end
                end
            end
            S_UNITS: begin
                if (w_press) begin
                    if (digit > MAX_DIGIT) begin
                        w_err_nxt = 1'b1;
                    end else if (w_legal) begin
                        w_value_nxt = neg ? Bits'(w_neg_mag) : Bits'(w_mag);
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_tens_nxt  = 4'd0;
                        w_state_nxt = S_TENS;
                    end
                end
            end
            S_DONE: begin
                if (ack) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_TENS;
                end
            end
            default: begin
                w_state_nxt = S_TENS;
            end
        endcase
    end

    assign value = r_value;
    assign valid = r_valid;
    assign err   = r_err;
    assign stage = r_stage;

endmodule

// File: tb/tb_operand_entry.sv
// Randomized and directed bench for operand_entry with an event scoreboard.
module tb_operand_entry;

    localparam int unsigned B = 5;

    logic         clk;
    logic         rst;
    logic         key;
    logic [3:0]   digit;
    logic         neg;
    logic         ack;
    logic [B-1:0] value;
    logic         valid;
    logic         err;
    logic [3:0]   stage;

    int errors;
    int checks;

    typedef struct {
        bit           is_acc;
        logic [B-1:0] val;
    } ev_t;

    ev_t exp_q[$];

    // Reference model: phase 0 = tens, 1 = units, 2 = done.
    int           m_phase;
    int           m_tens;
    logic [B-1:0] m_value;
    bit           m_valid;

    operand_entry #(.Bits(B)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .digit (digit),
        .neg   (neg),
        .ack   (ack),
        .value (value),
        .valid (valid),
        .err   (err),
        .stage (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_ev(input bit is_acc, input logic [B-1:0] v);
        ev_t e;
        e.is_acc = is_acc;
        e.val    = v;
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_tens  = 0;
        m_value = '0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_press(input int d, input bit n);
        int mag;
        int lim;
        if (m_phase == 2) return;
        if (d > 9) begin
            push_ev(1'b0, '0);
            return;
        end
        if (m_phase == 0) begin
            m_tens  = d;
            m_phase = 1;
            return;
        end
        mag = 10 * m_tens + d;
        lim = n ? (1 << (B - 1)) : (1 << (B - 1)) - 1;
        if (mag <= lim) begin
            m_value = B'(n ? -mag : mag);
            m_valid = 1'b1;
            m_phase = 2;
            push_ev(1'b1, m_value);
        end else begin
            m_tens  = 0;
            m_phase = 0;
            push_ev(1'b0, '0);
        end
    endfunction

    function automatic void model_ack();
        if (m_phase == 2) begin
            m_valid = 1'b0;
            m_phase = 0;
        end
    endfunction

    task automatic do_press(input logic [3:0] d, input logic n);
        @(posedge clk); #1;
        digit = d; neg = n; key = 1'b1;
        model_press(int'(d), n);
        @(posedge clk); #1;
        key = 1'b0;
    endtask

    task automatic do_ack();
        @(posedge clk); #1;
        ack = 1'b1;
        model_ack();
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    task automatic do_ack_press(input logic [3:0] d, input logic n);
        @(posedge clk); #1;
        ack = 1'b1; key = 1'b1; digit = d; neg = n;
        if (m_phase == 2) model_ack();
        else model_press(int'(d), n);
        @(posedge clk); #1;
        ack = 1'b0; key = 1'b0;
    endtask

    task automatic hold_key(input logic [3:0] d, input logic n, input int cyc);
        @(posedge clk); #1;
        digit = d; neg = n; key = 1'b1;
        model_press(int'(d), n);
        repeat (cyc) @(posedge clk);
        #1 key = 1'b0;
    endtask

    task automatic do_reset(input int cyc, input logic keyhold);
        @(posedge clk); #1;
        rst = 1'b1; key = keyhold;
        model_reset();
        repeat (cyc) @(posedge clk);
        #1 rst = 1'b0;
        if (keyhold) begin
            repeat (3) @(posedge clk);
            #1 key = 1'b0;
        end
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name);
        logic [3:0] exp_stage;
        exp_stage = 4'(1 << m_phase);
        @(negedge clk);
        checks++;
        if (stage !== exp_stage) begin
            errors++;
            $display("FAIL %s.stage: got %b want %b", name, stage, exp_stage);
        end
        checks++;
        if (valid !== m_valid) begin
            errors++;
            $display("FAIL %s.valid: got %b want %b", name, valid, m_valid);
        end
        checks++;
        if (value !== m_value) begin
            errors++;
            $display("FAIL %s.value: got %b want %b", name, value, m_value);
        end
    endtask

    task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Monitor: every err pulse and every rising valid consumes one expected event.
    initial begin : monitor
        logic prev_valid;
        ev_t  e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (err) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL err_pulse: got unexpected reject at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_acc) begin
                            errors++;
                            $display("FAIL event_kind: got reject want accept of %b", e.val);
                        end
                    end
                end
                if (valid && !prev_valid) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL accept: got unexpected value %b at %0t", value, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (!e.is_acc) begin
                            errors++;
                            $display("FAIL event_kind: got accept %b want reject", value);
                        end else if (value !== e.val) begin
                            errors++;
                            $display("FAIL accept_value: got %b want %b", value, e.val);
                        end
                    end
                end
                prev_valid = valid;
            end
        end
    end

    initial begin
        int r;
        logic [3:0] d;
        logic n;
        errors = 0;
        checks = 0;
        rst = 1'b1; key = 1'b0; digit = 4'd0; neg = 1'b0; ack = 1'b0;
        model_reset();
        idle(3);
        rst = 1'b0;
        check_state("reset");
        check_lit("reset_stage", 8'(stage), 8'b0001);
        check_lit("reset_err", 8'(err), 8'd0);

        // +12 then ack
        do_press(4'd1, 1'b0);
        do_press(4'd2, 1'b0);
        check_state("pos12");
        check_lit("pos12_value", 8'(value), 8'b01100);
        check_lit("pos12_stage", 8'(stage), 8'b0100);
        do_ack();
        check_state("pos12_ack");
        check_lit("pos12_ack_value", 8'(value), 8'b01100);

        // -16 legal, +16 rejected
        do_press(4'd1, 1'b1);
        do_press(4'd6, 1'b1);
        check_state("neg16");
        check_lit("neg16_value", 8'(value), 8'b10000);
        do_ack();
        do_press(4'd1, 1'b0);
        do_press(4'd6, 1'b0);
        check_state("pos16_rej");
        check_lit("pos16_rej_value", 8'(value), 8'b10000);

        // Bad digits in both stages, then -7
        do_press(4'hA, 1'b0);
        check_state("bad_tens");
        do_press(4'd0, 1'b0);
        do_press(4'hF, 1'b0);
        check_state("bad_units");
        check_lit("bad_units_stage", 8'(stage), 8'b0010);
        do_press(4'd7, 1'b1);
        check_state("neg7");
        check_lit("neg7_value", 8'(value), 8'b11001);
        do_ack();

        // Held key, key held across reset, presses in DONE, ack+press
        hold_key(4'd2, 1'b0, 10);
        check_state("hold10");
        do_reset(2, 1'b1);
        check_state("key_over_reset");
        do_press(4'd1, 1'b0);
        do_press(4'd0, 1'b0);
        check_state("pos10");
        do_press(4'd5, 1'b0);
        check_state("done_press");
        do_ack_press(4'd3, 1'b0);
        check_state("ack_press");
        idle(3);
        check_state("ack_press_idle");
        do_press(4'd3, 1'b0);
        check_state("after_ack_press");

        // Reset mid-entry
        do_reset(1, 1'b0);
        check_state("mid_reset");
        check_lit("mid_reset_err", 8'(err), 8'd0);
        do_press(4'd0, 1'b0);
        do_press(4'd3, 1'b0);
        check_state("pos3");
        check_lit("pos3_value", 8'(value), 8'b00011);
        do_ack();

        // -0
        do_press(4'd0, 1'b1);
        do_press(4'd0, 1'b1);
        check_state("neg0");
        check_lit("neg0_value", 8'(value), 8'd0);
        do_ack();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) d = 4'($urandom_range(10, 15));
            else if (m_phase == 0) d = 4'($urandom_range(0, 3));
            else d = 4'($urandom_range(0, 9));
            if (r < 60) do_press(d, n);
            else if (r < 80) do_ack();
            else if (r < 88) do_ack_press(d, n);
            else if (r < 90) do_reset(1, 1'($urandom_range(0, 1)));
            else idle(1);
            check_state("rand");
        end

        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending events want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
